// File: rtl/mem_io_responder_if.sv
// CPU byte bus, UART TX/RX streams and stop flag between a CPU-side master and the responder.
// Signal names follow the memory-map contract; clock and reset are kept outside the interface.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_stop;

    modport slave (
        input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, prog_stop
    );

    modport master (
        output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, prog_stop
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped UART TX FIFO / RX holding register / cycle counter (counter built only with MEM_IO_CYCLE_CNT_EN).
// Latency: RAM write 0 wait, every read returns on mem_din one cycle later.
// Backpressure: none toward the CPU; TX pushes to a full FIFO are dropped, io_buffer_full warns two entries early.

// Generic synchronous FIFO with occupancy outputs.
// Latency: push visible at pop side one cycle later.
// Backpressure: push accepted only while not full, pop only while non-empty.
module mem_io_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [W-1:0]     pop_dat,
    input  logic             pop_rdy,
    output logic [CNT_W-1:0] lvl,
    output logic [CNT_W-1:0] lvl_nxt
);
    logic [W-1:0]     store_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] lvl_q, lvl_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_rdy = (lvl_q != CNT_W'(DEPTH));
    assign pop_vld  = (lvl_q != '0);
    assign push_ok  = push_vld && push_rdy;
    assign pop_ok   = pop_rdy && pop_vld;
    assign pop_dat  = pop_vld ? store_mem[rd_ptr_q] : '0;
    assign lvl      = lvl_q;
    assign lvl_nxt  = lvl_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        lvl_d    = lvl_q;
        if (push_ok && !pop_ok) begin
            lvl_d = lvl_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            lvl_d = lvl_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            store_mem[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// Memory/IO responder top: RAM below the IO window, UART and counter registers inside it.
// Latency: registered read data one cycle after the request, TX byte visible one cycle after the push.
// Backpressure: tx_valid/tx_ready toward UART, rx_ready low while a received byte is unread.
module mem_io_responder #(
    parameter int ADDR_W   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus
);
    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    logic [7:0]        ram_mem [1 << ADDR_W];
    logic [7:0]        ram_rd_q;
    logic              rd_ram_sel_q, rd_ram_sel_d;
    logic [7:0]        io_rd_q, io_rd_d;
    logic              rx_full_q, rx_full_d;
    logic [7:0]        rx_dat_q, rx_dat_d;
    logic              prog_stop_q, prog_stop_d;
    logic              io_buffer_full_q, io_buffer_full_d;

    logic              io_sel;
    logic [15:0]       io_off;
    logic [ADDR_W-1:0] ram_addr;
    logic              wr_ram, rd_ram, rd_io;
    logic              stop_wr;
    logic              rx_take, rx_load;
    logic              tx_push_vld;
    logic [7:0]        tx_push_dat;
    logic [CNT_W-1:0]  tx_lvl, tx_lvl_nxt;
    logic [7:0]        cnt_byte;
    logic              unused_push_rdy;
    logic [CNT_W-1:0]  unused_lvl;
    logic              unused_addr_hi;

    assign io_sel   = (bus.mem_a[17:16] == 2'b11);
    assign io_off   = bus.mem_a[15:0];
    assign ram_addr = bus.mem_a[ADDR_W-1:0];
    assign wr_ram   = bus.mem_wr && !io_sel;
    assign rd_ram   = !bus.mem_wr && !io_sel;
    assign rd_io    = !bus.mem_wr && io_sel;
    assign stop_wr  = bus.mem_wr && io_sel && (io_off == 16'h0004);
    assign rx_take  = rd_io && (io_off == 16'h0000);
    assign rx_load  = bus.rx_valid && !rx_full_q;

    // The stop write enqueues a NUL so the UART side sees end-of-program in band.
    assign tx_push_vld = stop_wr ||
                         (bus.mem_wr && io_sel && (io_off == 16'h0000) && (bus.mem_dout != 8'h00));
    assign tx_push_dat = stop_wr ? 8'h00 : bus.mem_dout;

    assign unused_lvl     = tx_lvl;
    assign unused_addr_hi = ^bus.mem_a[31:18];

    mem_io_fifo #(
        .W     (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk_in),
        .arst_n   (rst_in),
        .push_vld (tx_push_vld),
        .push_dat (tx_push_dat),
        .push_rdy (unused_push_rdy),
        .pop_vld  (bus.tx_valid),
        .pop_dat  (bus.tx_data),
        .pop_rdy  (bus.tx_ready),
        .lvl      (tx_lvl),
        .lvl_nxt  (tx_lvl_nxt)
    );

`ifdef MEM_IO_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    assign cyc_d    = prog_stop_q ? cyc_q : cyc_q + 32'd1;
    assign cnt_byte = cyc_q[{bus.mem_a[1:0], 3'b000} +: 8];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`else
    assign cnt_byte = 8'h00;
`endif

    always_comb begin
        rx_full_d        = rx_full_q;
        rx_dat_d         = rx_dat_q;
        io_rd_d          = io_rd_q;
        rd_ram_sel_d     = rd_ram_sel_q;
        prog_stop_d      = prog_stop_q || stop_wr;
        io_buffer_full_d = (tx_lvl_nxt >= CNT_W'(TX_DEPTH - 2));

        // Take before load: an empty register read in the same cycle as a load returns 0 and keeps the new byte.
        if (rx_take) begin
            rx_full_d = 1'b0;
        end
        if (rx_load) begin
            rx_full_d = 1'b1;
            rx_dat_d  = bus.rx_data;
        end

        if (rd_ram) begin
            rd_ram_sel_d = 1'b1;
        end else if (rd_io) begin
            rd_ram_sel_d = 1'b0;
            io_rd_d      = 8'h00;
            if (io_off == 16'h0000) begin
                io_rd_d = rx_full_q ? rx_dat_q : 8'h00;
            end else if (io_off[15:2] == 14'h0001) begin
                io_rd_d = cnt_byte;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_full_q        <= 1'b0;
            rx_dat_q         <= 8'h00;
            io_rd_q          <= 8'h00;
            rd_ram_sel_q     <= 1'b0;
            prog_stop_q      <= 1'b0;
            io_buffer_full_q <= 1'b0;
        end else begin
            rx_full_q        <= rx_full_d;
            rx_dat_q         <= rx_dat_d;
            io_rd_q          <= io_rd_d;
            rd_ram_sel_q     <= rd_ram_sel_d;
            prog_stop_q      <= prog_stop_d;
            io_buffer_full_q <= io_buffer_full_d;
        end
    end

    // RAM has no reset so it maps onto block memory; the read-source flag masks its data after reset.
    always_ff @(posedge clk_in) begin
        if (wr_ram) begin
            ram_mem[ram_addr] <= bus.mem_dout;
        end
        if (rd_ram) begin
            ram_rd_q <= ram_mem[ram_addr];
        end
    end

    assign bus.mem_din        = rd_ram_sel_q ? ram_rd_q : io_rd_q;
    assign bus.io_buffer_full = io_buffer_full_q;
    assign bus.rx_ready       = !rx_full_q;
    assign bus.prog_stop      = prog_stop_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX queue with scoreboard, RX register, counter, stop and reset.
module tb_mem_io_responder;
    logic clk;
    logic rst_in;
    int   checks_total;
    int   checks_passed;
    int   tb_cyc;
    logic [7:0] exp_q[$];

`ifdef MEM_IO_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    mem_io_responder_if bus ();

    mem_io_responder #(
        .ADDR_W   (17),
        .TX_DEPTH (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Independent cycle count: edges seen since reset release.
    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) tb_cyc <= 0;
        else         tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // TX scoreboard: every byte the UART consumes must be the next expected one.
    always @(negedge clk) begin
        if (rst_in && bus.tx_valid && bus.tx_ready) begin
            check("tx_expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [31:0] a, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_dout = d;
        bus.mem_wr   = 1'b1;
        tick();
        bus.mem_wr   = 1'b0;
        bus.mem_a    = '0;
        bus.mem_dout = '0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [7:0] d);
        bus.mem_a  = a;
        bus.mem_wr = 1'b0;
        tick();
        d = bus.mem_din;
        bus.mem_a = '0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [31:0] snap;
        logic [31:0] frozen;
        logic [31:0] exp_cnt;

        clk = 1'b0;
        rst_in = 1'b0;
        checks_total = 0;
        checks_passed = 0;
        bus.mem_a = '0;
        bus.mem_dout = '0;
        bus.mem_wr = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;

        #12;
        check("rst_mem_din", 32'(bus.mem_din), 32'h0);
        check("rst_io_buffer_full", 32'(bus.io_buffer_full), 32'h0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'h1);
        check("rst_prog_stop", 32'(bus.prog_stop), 32'h0);
        tick();
        rst_in = 1'b1;
        tick();

        // RAM write then read in the following cycle, plus the top RAM byte.
        io_write(32'h0001_0, 8'hA5);
        do_read(32'h0001_0, rd);
        check("ram_rd_after_wr", 32'(rd), 32'hA5);
        io_write(32'h0001_FFFF, 8'h5A);
        io_write(32'h0000_0011, 8'h3C);
        do_read(32'h0001_FFFF, rd);
        check("ram_top_byte", 32'(rd), 32'h5A);
        do_read(32'h0000_0011, rd);
        check("ram_second_byte", 32'(rd), 32'h3C);

        // TX stream with NUL filtered out.
        bus.tx_ready = 1'b1;
        exp_q.push_back(8'h41);
        io_write(32'h0003_0000, 8'h41);
        io_write(32'h0003_0000, 8'h00);
        exp_q.push_back(8'h42);
        io_write(32'h0003_0000, 8'h42);
        wait_drain("tx_drain_basic");
        tick();
        check("tx_idle_after_drain", 32'(bus.tx_valid), 32'h0);

        // Fill with UART stalled: warning at 6 entries, drops beyond 8.
        bus.tx_ready = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n <= 8) exp_q.push_back(8'(n));
            io_write(32'h0003_0000, 8'(n));
            if (n == 5) check("buf_full_at5", 32'(bus.io_buffer_full), 32'h0);
            if (n == 6) check("buf_full_at6", 32'(bus.io_buffer_full), 32'h1);
        end
        check("buf_full_when_full", 32'(bus.io_buffer_full), 32'h1);
        check("tx_valid_when_full", 32'(bus.tx_valid), 32'h1);
        check("tx_head_when_full", 32'(bus.tx_data), 32'h01);
        bus.tx_ready = 1'b1;
        wait_drain("tx_drain_overflow");
        tick();
        check("buf_full_after_drain", 32'(bus.io_buffer_full), 32'h0);
        check("tx_valid_after_drain", 32'(bus.tx_valid), 32'h0);

        // Unmapped IO: write ignored, read zero.
        io_write(32'h0003_0008, 8'h77);
        tick();
        check("io_unmapped_wr_ignored", 32'(bus.tx_valid), 32'h0);
        do_read(32'h0003_0008, rd);
        check("io_unmapped_rd", 32'(rd), 32'h00);

        // RX holding register.
        check("rx_ready_idle", 32'(bus.rx_ready), 32'h1);
        bus.rx_data = 8'h7E;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        check("rx_ready_loaded", 32'(bus.rx_ready), 32'h0);
        bus.rx_data = 8'h55;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        do_read(32'h0003_0001, rd);
        check("rx_offset1_zero", 32'(rd), 32'h00);
        check("rx_still_held", 32'(bus.rx_ready), 32'h0);
        do_read(32'h0003_0000, rd);
        check("rx_first_read", 32'(rd), 32'h7E);
        check("rx_ready_after_read", 32'(bus.rx_ready), 32'h1);
        do_read(32'h0003_0000, rd);
        check("rx_second_read", 32'(rd), 32'h00);

        // Running counter, little-endian bytes.
        for (int i = 0; i < 4; i++) begin
            snap = 32'(tb_cyc);
            do_read(32'h0003_0004 + 32'(i), rd);
            exp_cnt = CNT_EN ? (snap >> (8 * i)) & 32'hFF : 32'h0;
            check("cnt_running_byte", 32'(rd), exp_cnt);
        end

        // Stop near cycle 100: NUL on TX, sticky flag, frozen counter.
        for (int i = 0; i < 200; i++) begin
            if (tb_cyc >= 99) break;
            tick();
        end
        snap = 32'(tb_cyc);
        frozen = CNT_EN ? snap + 32'd1 : 32'h0;
        exp_q.push_back(8'h00);
        io_write(32'h0003_0004, 8'hFF);
        check("prog_stop_set", 32'(bus.prog_stop), 32'h1);
        wait_drain("tx_drain_stop");
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                do_read(32'h0003_0004 + 32'(i), rd);
                check("cnt_frozen_byte", 32'(rd), (frozen >> (8 * i)) & 32'hFF);
            end
            repeat (20) tick();
        end
        check("prog_stop_sticky", 32'(bus.prog_stop), 32'h1);

        // Asynchronous reset with 3 queued TX bytes and a held RX byte.
        bus.tx_ready = 1'b0;
        io_write(32'h0003_0000, 8'h11);
        io_write(32'h0003_0000, 8'h22);
        io_write(32'h0003_0000, 8'h33);
        bus.rx_data = 8'h99;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        check("pre_rst_tx_valid", 32'(bus.tx_valid), 32'h1);
        check("pre_rst_rx_ready", 32'(bus.rx_ready), 32'h0);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("arst_tx_data", 32'(bus.tx_data), 32'h0);
        check("arst_prog_stop", 32'(bus.prog_stop), 32'h0);
        check("arst_rx_ready", 32'(bus.rx_ready), 32'h1);
        check("arst_mem_din", 32'(bus.mem_din), 32'h0);
        tick();
        rst_in = 1'b1;
        bus.tx_ready = 1'b1;
        repeat (3) tick();
        check("post_rst_tx_empty", 32'(bus.tx_valid), 32'h0);
        snap = 32'(tb_cyc);
        do_read(32'h0003_0004, rd);
        check("cnt_restart", 32'(rd), CNT_EN ? snap & 32'hFF : 32'h0);
        do_read(32'h0003_0000, rd);
        check("rx_discarded", 32'(rd), 32'h00);
        do_read(32'h0001_0, rd);
        check("ram_kept_over_reset", 32'(rd), 32'hA5);

        wait_drain("tx_final_empty");
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
